// File: rtl/sys_inpbuf_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sys_inpbuf_fifo
//  Purpose  : Multi-lane input FIFO that feeds systolic-array row/column
//             edges. Each entry is one NCH-lane vector of WORDLEN-bit words,
//             pushed and popped as a single unit. Provides full/empty flags,
//             occupancy count, an almost-full threshold and a synchronous
//             flush. Single clock domain.
//  Ports    : clk      - clock, all logic on rising edge
//             rstn     - synchronous active-low reset
//             flush    - synchronous clear of contents and error flags
//             wr_en    - push request (ignored while full)
//             wr_data  - push vector, lane i = [i*WORDLEN +: WORDLEN]
//             full     - count == DEPTH
//             afull    - count >= AFULL_TH
//             rd_en    - pop request (ignored while empty)
//             rd_data  - registered pop data, holds when no pop
//             rd_valid - rd_data was loaded by a pop on the previous edge
//             empty    - count == 0
//             count    - occupancy 0..DEPTH
//             err_ovf  - sticky push-while-full
//             err_udf  - sticky pop-while-empty
//  Config   : define INPBUF_ERR_EN to build the sticky error registers;
//             without it err_ovf/err_udf are tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module sys_inpbuf_fifo #(
    parameter int WORDLEN  = 8,
    parameter int NCH      = 4,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = 14
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [NCH*WORDLEN-1:0]   wr_data,
    output logic                     full,
    output logic                     afull,
    input  logic                     rd_en,
    output logic [NCH*WORDLEN-1:0]   rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_ovf,
    output logic                     err_udf
);

    localparam int             AW         = $clog2(DEPTH);
    localparam int             c_ew       = NCH * WORDLEN;
    localparam logic [AW:0]    c_afull_th = (AW+1)'(AFULL_TH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the low address bits match.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [c_ew-1:0]  r_mem [DEPTH];
    logic [c_ew-1:0]  r_rd_data;
    logic             r_rd_valid;

    logic             w_full;
    logic             w_empty;
    logic [AW:0]      w_count;
    logic             w_push;
    logic             w_pop;

    // Flags derive only from registered pointers, so a same-cycle push and pop
    // are each judged against the state before the edge.
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_count = r_wptr - r_rptr;

    // Flush drops any request in the same cycle; reset wins over everything.
    assign w_push = rstn && !flush && wr_en && !w_full;
    assign w_pop  = rstn && !flush && rd_en && !w_empty;

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + 1'b1;
                r_rd_data <= r_mem[r_rptr[AW-1:0]];
            end
            r_rd_valid <= w_pop;
        end
    end

`ifdef INPBUF_ERR_EN
    logic r_err_ovf;
    logic r_err_udf;

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_err_ovf <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = w_count;
    assign afull    = (w_count >= c_afull_th);
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire
